// File: rtl/div_req_ctrl.sv
// div_req_ctrl: request-side controller for the 16-bit signed sequential divider.
// Queues divide requests, launches the divider with a one-cycle start pulse,
// and returns quotient/remainder with the request tag over a valid/ready port.
// Optional macro DIV_DBZ_BYPASS_EN: zero-divisor requests skip the divider and
// return q=16'hFFFF, r=dividend with rsp_dbz=1.
module div_req_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [15:0]      req_dividend,
    input  logic [15:0]      req_divisor,
    input  logic [TAG_W-1:0] req_tag,
    output logic             div_start,
    output logic [15:0]      div_dividend,
    output logic [15:0]      div_divisor,
    input  logic [15:0]      div_quotient,
    input  logic [15:0]      div_remainder,
    input  logic             div_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_quotient,
    output logic [15:0]      rsp_remainder,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_dbz,
    output logic             busy
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = 32 + TAG_W;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state, state_next;

    // FIFO entry layout: {tag, divisor, dividend}
    logic [ENTRY_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;
    logic               push, pop, full, empty;
    logic [ENTRY_W-1:0] head;
    logic [15:0]        head_dividend, head_divisor;
    logic [TAG_W-1:0]   head_tag;
    logic [TAG_W-1:0]   op_tag;
    logic               head_dbz;
    logic               capture, bypass;

    assign full          = (count == FULL_CNT);
    assign empty         = (count == '0);
    assign req_ready     = !full;
    assign push          = req_valid && req_ready;
    assign head          = fifo_mem[rd_ptr];
    assign head_dividend = head[15:0];
    assign head_divisor  = head[31:16];
    assign head_tag      = head[ENTRY_W-1:32];
    assign busy          = (state != IDLE) || !empty;

`ifdef DIV_DBZ_BYPASS_EN
    assign head_dbz = (head_divisor == '0);
`else
    assign head_dbz = 1'b0;
`endif

    // FIFO storage: write the tail entry on every accepted request
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_tag, req_divisor, req_dividend};
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        bypass     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_dbz) begin
                        bypass     = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (div_done) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, FIFO pointers, operand and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            div_start     <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            op_tag        <= '0;
            rsp_valid     <= 1'b0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_tag       <= '0;
        end else begin
            state <= state_next;
            // start is registered so it is high exactly while the FSM sits in ISSUE
            div_start <= (state_next == ISSUE);

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end

            if (pop && !bypass) begin
                div_dividend <= head_dividend;
                div_divisor  <= head_divisor;
                op_tag       <= head_tag;
            end

            if (capture) begin
                rsp_valid     <= 1'b1;
                rsp_quotient  <= div_quotient;
                rsp_remainder <= div_remainder;
                rsp_tag       <= op_tag;
            end else if (bypass) begin
                rsp_valid     <= 1'b1;
                rsp_quotient  <= '1;
                rsp_remainder <= head_dividend;
                rsp_tag       <= head_tag;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef DIV_DBZ_BYPASS_EN
    // Divide-by-zero flag: set by a bypassed head, cleared by any other head
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_dbz <= 1'b0;
        end else if (pop) begin
            rsp_dbz <= bypass;
        end
    end
`else
    assign rsp_dbz = 1'b0;
`endif

endmodule
